// File: rtl/axi4_burst_split_if.sv
// Request/command bundle for axi4_burst_split.
// slave: the splitter's view; master: the requester/consumer view.
interface axi4_burst_split_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [CNT_WIDTH-1:0]  req_beats_i;
    logic                  cmd_valid_o;
    logic                  cmd_ready_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_o;
    logic [7:0]            cmd_len_o;
    logic [2:0]            cmd_size_o;
    logic [1:0]            cmd_burst_o;
    logic                  cmd_last_o;
    logic                  done_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_beats_i, cmd_ready_i,
        output req_ready_o, cmd_valid_o, cmd_addr_o, cmd_len_o,
        output cmd_size_o, cmd_burst_o, cmd_last_o, done_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_beats_i, cmd_ready_i,
        input  req_ready_o, cmd_valid_o, cmd_addr_o, cmd_len_o,
        input  cmd_size_o, cmd_burst_o, cmd_last_o, done_o
    );
endinterface

// File: rtl/axi4_burst_split.sv
// Splits a linear (addr, beats) request into AXI4 INCR commands that
// never cross 4KB nor exceed MAX_BEATS. Ports: clk_i, rst_i, bus (slave).
module axi4_burst_split #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_BYTES = 8,
    parameter int MAX_BEATS  = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    axi4_burst_split_if.slave bus
);
    localparam int SZ = $clog2(DATA_BYTES);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;
    logic                  done_q, done_d;

    logic [12:0]           b4k;
    logic [12:0]           lim;
    logic [8:0]            beats;
    logic [ADDR_WIDTH-1:0] align_mask;

    // 13 bits: b4k reaches 4096 when DATA_BYTES == 1
    assign b4k = (13'd4096 - {1'b0, addr_q[11:0]}) >> SZ;
    assign lim = (b4k < 13'(MAX_BEATS)) ? b4k : 13'(MAX_BEATS);
    assign beats = (rem_q < CNT_WIDTH'(lim)) ? 9'(rem_q) : 9'(lim);
    assign align_mask = ~ADDR_WIDTH'(DATA_BYTES - 1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        done_d          = 1'b0;
        bus.req_ready_o = 1'b0;
        bus.cmd_valid_o = 1'b0;
        bus.cmd_len_o   = 8'd0;
        bus.cmd_last_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) begin
                    addr_d = bus.req_addr_i & align_mask;
                    rem_d  = bus.req_beats_i;
                    if (bus.req_beats_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                bus.cmd_valid_o = 1'b1;
                bus.cmd_len_o   = 8'(beats - 9'd1);
                bus.cmd_last_o  = (rem_q == CNT_WIDTH'(beats));
                if (bus.cmd_ready_i) begin
                    addr_d = addr_q + (ADDR_WIDTH'(beats) << SZ);
                    rem_d  = rem_q - CNT_WIDTH'(beats);
                    if (bus.cmd_last_o) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_addr_o  = addr_q;
    assign bus.cmd_size_o  = 3'(SZ);
    assign bus.cmd_burst_o = 2'b01;
    assign bus.done_o      = done_q;
endmodule
